register_bank: RTL and testbench

Parametrised successor to the fixed four-entry bus register: a bank of NUM_REGS registers of DATA_WIDTH bits on the shared tri-state data bus. Adds a small access state machine, a registered read path, a ready/error handshake, full address decode with out-of-range detection, and per-register write protection. It sits between the bus controller and the shared bus and drives the bus only through the existing tri_state_buffer.

---
 rtl/register_pkg.sv | 15 +
 rtl/tri_state_buffer.sv | 13 +
 rtl/register_bank.sv | 132 +++++++++++++
 tb/tb_register_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared definitions for the register bank and future bus peripherals.
package register_pkg;

  // Access state machine encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Default bus geometry shared by bus peripherals.
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 6;

endpackage

// File: rtl/tri_state_buffer.sv
// Drives the shared bus with data_in while enabled, releases it (Z) otherwise.
module tri_state_buffer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  output tri   [WIDTH-1:0] data_out
);

  // Bus driver: only one peripheral may enable at a time.
  assign data_out = enable ? data_in : {WIDTH{1'bz}};

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers on the shared tri-state bus with a small
// IDLE/WRITE/READ access FSM, registered read data and ready/error handshake.
module register_bank
  import register_pkg::*;
#(
  parameter int                  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                  NUM_REGS   = 4,
  parameter int                  ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                  register_clock,
  input  logic                  register_reset_n,
  input  logic [ADDR_WIDTH-1:0] register_addr,
  input  logic [DATA_WIDTH-1:0] bus_register_input,
  input  logic                  bus_register_input_en,
  input  logic                  bus_register_out_en,
  output tri   [DATA_WIDTH-1:0] bus_register_output,
  output logic                  register_ready,
  output logic                  register_error
);

  // Index width into the array; the full address is still decoded for range.
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  state_t                state;
  state_t                next_state;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  acc_err;

  logic                  in_range;
  logic [IDX_W-1:0]      addr_idx;
  logic                  addr_ro;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_REGS-1:0]   wr_en;

  // Address decode: range check on every address bit, then array lookup.
  always_comb begin
    in_range = ({1'b0, register_addr} < NUM_REGS_W);
    addr_idx = register_addr[IDX_W-1:0];
    addr_ro  = 1'b0;
    rd_word  = '0;
    if (in_range) begin
      addr_ro = RO_MASK[addr_idx];
      rd_word = regs[addr_idx];
    end
  end

  // One write strobe per register, only for a valid access in WRITE.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
    assign wr_en[gi] = (state == WRITE) && !acc_err && (wr_idx == IDX_W'(gi));
  end

  // Register array; reset value of each entry is its own index.
  always_ff @(posedge register_clock or negedge register_reset_n) begin
    if (!register_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_WIDTH'(i);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) regs[i] <= wr_data;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge register_clock or negedge register_reset_n) begin
    if (!register_reset_n) state <= IDLE;
    else                   state <= next_state;
  end

  // Next-state logic: write wins over read; a held read streams in READ.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus_register_input_en)    next_state = WRITE;
        else if (bus_register_out_en) next_state = READ;
      end
      WRITE: next_state = IDLE;
      READ: begin
        if (!(bus_register_out_en && !bus_register_input_en)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Access datapath: capture write target/data or read word plus error flag.
  always_ff @(posedge register_clock or negedge register_reset_n) begin
    if (!register_reset_n) begin
      wr_idx  <= '0;
      wr_data <= '0;
      rd_data <= '0;
      acc_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_register_input_en) begin
            wr_idx  <= addr_idx;
            wr_data <= bus_register_input;
            acc_err <= !in_range || addr_ro;
          end else if (bus_register_out_en) begin
            rd_data <= rd_word;
            acc_err <= !in_range;
          end
        end
        READ: begin
          if (bus_register_out_en && !bus_register_input_en) begin
            rd_data <= rd_word;
            acc_err <= !in_range;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs come from registered state only.
  assign register_ready = (state != IDLE);
  assign register_error = (state != IDLE) && acc_err;

  tri_state_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_bus_driver (
    .data_in (rd_data),
    .enable  (state == READ),
    .data_out(bus_register_output)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: NUM_REGS=4, register 1 read-only.
// The bus net has a pull-up, so a released bus reads as 16'hFFFF.
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic [5:0]  addr;
  logic [15:0] din;
  logic        in_en;
  logic        out_en;
  tri1  [15:0] bus;
  logic        ready;
  logic        err;

  int checks;
  int errors;

  localparam logic [15:0] RELEASED = 16'hFFFF;

  register_bank #(
    .DATA_WIDTH(16),
    .NUM_REGS  (4),
    .ADDR_WIDTH(6),
    .RO_MASK   (4'b0010)
  ) dut (
    .register_clock       (clk),
    .register_reset_n     (rst_n),
    .register_addr        (addr),
    .bus_register_input   (din),
    .bus_register_input_en(in_en),
    .bus_register_out_en  (out_en),
    .bus_register_output  (bus),
    .register_ready       (ready),
    .register_error       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single read from IDLE: one ready cycle, then back to IDLE.
  task automatic read_one(input logic [5:0] a, input logic [15:0] exp, input logic exp_err);
    addr   = a;
    out_en = 1'b1;
    tick();
    out_en = 1'b0;
    $display("read  addr=%0d bus=%h ready=%b err=%b", a, bus, ready, err);
    check("rd_ready", {15'd0, ready}, 16'd1);
    check("rd_err",   {15'd0, err},   {15'd0, exp_err});
    check("rd_bus",   bus,            exp);
    tick();
    check("rd_done_ready", {15'd0, ready}, 16'd0);
    check("rd_done_bus",   bus,            RELEASED);
  endtask

  // Single write from IDLE: one ready cycle with error flag, bus released.
  task automatic write_one(input logic [5:0] a, input logic [15:0] d, input logic exp_err);
    addr  = a;
    din   = d;
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    $display("write addr=%0d data=%h ready=%b err=%b", a, d, ready, err);
    check("wr_ready", {15'd0, ready}, 16'd1);
    check("wr_err",   {15'd0, err},   {15'd0, exp_err});
    check("wr_bus",   bus,            RELEASED);
    tick();
    check("wr_done_ready", {15'd0, ready}, 16'd0);
    check("wr_done_err",   {15'd0, err},   16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    addr   = '0;
    din    = '0;
    in_en  = 1'b0;
    out_en = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", {15'd0, ready}, 16'd0);
    check("rst_err",   {15'd0, err},   16'd0);
    check("rst_bus",   bus,            RELEASED);
    rst_n = 1'b1;
    tick();
    check("idle_ready", {15'd0, ready}, 16'd0);
    check("idle_bus",   bus,            RELEASED);

    // Reset values are the register indices
    read_one(6'd0, 16'h0000, 1'b0);
    read_one(6'd1, 16'h0001, 1'b0);
    read_one(6'd2, 16'h0002, 1'b0);
    read_one(6'd3, 16'h0003, 1'b0);

    // Write then read back
    write_one(6'd2, 16'hBEEF, 1'b0);
    read_one(6'd2, 16'hBEEF, 1'b0);

    // Streaming read of 0..3 with out_en held
    addr   = 6'd0;
    out_en = 1'b1;
    tick();
    $display("stream addr=0 bus=%h ready=%b", bus, ready);
    check("st0_bus", bus, 16'h0000);
    check("st0_ready", {15'd0, ready}, 16'd1);
    addr = 6'd1;
    tick();
    $display("stream addr=1 bus=%h ready=%b", bus, ready);
    check("st1_bus", bus, 16'h0001);
    check("st1_ready", {15'd0, ready}, 16'd1);
    addr = 6'd2;
    tick();
    $display("stream addr=2 bus=%h ready=%b", bus, ready);
    check("st2_bus", bus, 16'hBEEF);
    check("st2_ready", {15'd0, ready}, 16'd1);
    addr = 6'd3;
    tick();
    $display("stream addr=3 bus=%h ready=%b", bus, ready);
    check("st3_bus", bus, 16'h0003);
    check("st3_ready", {15'd0, ready}, 16'd1);
    out_en = 1'b0;
    tick();
    check("st_end_ready", {15'd0, ready}, 16'd0);
    check("st_end_bus",   bus,            RELEASED);

    // Invalid accesses
    write_one(6'd5, 16'h1234, 1'b1);
    read_one(6'd0, 16'h0000, 1'b0);
    read_one(6'd1, 16'h0001, 1'b0);
    read_one(6'd2, 16'hBEEF, 1'b0);
    read_one(6'd3, 16'h0003, 1'b0);
    read_one(6'd63, 16'h0000, 1'b1);
    write_one(6'd1, 16'h5555, 1'b1);
    read_one(6'd1, 16'h0001, 1'b0);

    // Both requests in IDLE: write first, then the read after IDLE
    addr   = 6'd0;
    din    = 16'h1357;
    in_en  = 1'b1;
    out_en = 1'b1;
    tick();
    in_en = 1'b0;
    $display("collide write phase ready=%b err=%b bus=%h", ready, err, bus);
    check("col_wr_ready", {15'd0, ready}, 16'd1);
    check("col_wr_bus",   bus,            RELEASED);
    tick();
    $display("collide idle phase ready=%b", ready);
    check("col_idle_ready", {15'd0, ready}, 16'd0);
    tick();
    out_en = 1'b0;
    $display("collide read phase bus=%h ready=%b err=%b", bus, ready, err);
    check("col_rd_ready", {15'd0, ready}, 16'd1);
    check("col_rd_err",   {15'd0, err},   16'd0);
    check("col_rd_bus",   bus,            16'h1357);
    tick();
    check("col_end_ready", {15'd0, ready}, 16'd0);

    // Reset asserted during the WRITE cycle aborts the write
    addr  = 6'd3;
    din   = 16'hAAAA;
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    check("mid_wr_ready", {15'd0, ready}, 16'd1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-write ready=%b err=%b bus=%h", ready, err, bus);
    check("mid_rst_ready", {15'd0, ready}, 16'd0);
    check("mid_rst_err",   {15'd0, err},   16'd0);
    check("mid_rst_bus",   bus,            RELEASED);
    tick();
    rst_n = 1'b1;
    tick();
    read_one(6'd3, 16'h0003, 1'b0);
    read_one(6'd2, 16'h0002, 1'b0);
    read_one(6'd0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
